// File: rtl/penalty_match_ctl.sv
// Penalty shoot-out match controller: multi-player or solo, with timed kicks.
// Optional sudden death after a regulation tie is built when PENALTY_SUDDEN_DEATH_EN is defined.
module penalty_match_ctl #(
  parameter int unsigned ROUNDS       = 5,
  parameter int unsigned SCORE_W      = 4,
  parameter int unsigned SHOT_TIMEOUT = 65_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               solo_enable,
  input  logic               shot_done,
  input  logic               goal,
  output logic               shot_window,
  output logic               shooter,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic [SCORE_W-1:0] round_idx,
  output logic               sudden,
  output logic               match_over,
  output logic [1:0]         winner
);

  localparam int unsigned        TW       = (SHOT_TIMEOUT > 2) ? $clog2(SHOT_TIMEOUT) : 1;
  localparam logic [TW-1:0]      TMO_LAST = TW'(SHOT_TIMEOUT - 1);
  localparam logic [SCORE_W-1:0] CNT_MAX  = '1;
  localparam logic [SCORE_W-1:0] RND_LAST = SCORE_W'(ROUNDS);
  localparam int unsigned        CW       = SCORE_W + 2;
  localparam logic [CW-1:0]      ROUNDS_C = CW'(ROUNDS);

  typedef enum logic [1:0] {IDLE, WAIT_SHOT, EVAL, DONE} state_t;

  state_t             state, state_n;
  logic               solo, solo_n;
  logic [TW-1:0]      tcnt, tcnt_n;
  logic               shooter_n, window_n, over_n;
  logic [SCORE_W-1:0] score_a_n, score_b_n, round_n;
  logic [1:0]         winner_n, win;
  logic               fin, hit;
  logic [CW-1:0]      sa_w, sb_w, rem_a, rem_b;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [1:0] leader(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
    return (a > b) ? 2'b01 : ((b > a) ? 2'b10 : 2'b11);
  endfunction

  // Side A always kicks first in a pair, so after any kick A has taken round_idx+1.
  assign sa_w  = CW'(score_a);
  assign sb_w  = CW'(score_b);
  assign rem_a = ROUNDS_C - (CW'(round_idx) + CW'(1));
  assign rem_b = ROUNDS_C - (CW'(round_idx) + CW'(shooter));
  assign hit   = shot_done & goal;

`ifdef PENALTY_SUDDEN_DEATH_EN
  logic sudden_n;
`else
  assign sudden = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      solo        <= 1'b0;
      tcnt        <= '0;
      shooter     <= 1'b0;
      score_a     <= '0;
      score_b     <= '0;
      round_idx   <= '0;
      shot_window <= 1'b0;
      match_over  <= 1'b0;
      winner      <= '0;
`ifdef PENALTY_SUDDEN_DEATH_EN
      sudden      <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      solo        <= solo_n;
      tcnt        <= tcnt_n;
      shooter     <= shooter_n;
      score_a     <= score_a_n;
      score_b     <= score_b_n;
      round_idx   <= round_n;
      shot_window <= window_n;
      match_over  <= over_n;
      winner      <= winner_n;
`ifdef PENALTY_SUDDEN_DEATH_EN
      sudden      <= sudden_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    solo_n    = solo;
    tcnt_n    = tcnt;
    shooter_n = shooter;
    score_a_n = score_a;
    score_b_n = score_b;
    round_n   = round_idx;
    window_n  = shot_window;
    over_n    = match_over;
    winner_n  = winner;
    fin       = 1'b0;
    win       = 2'b00;
`ifdef PENALTY_SUDDEN_DEATH_EN
    sudden_n  = sudden;
`endif
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n   = WAIT_SHOT;
          solo_n    = solo_enable;
          shooter_n = solo_enable;
          tcnt_n    = '0;
          score_a_n = '0;
          score_b_n = '0;
          round_n   = '0;
          window_n  = 1'b1;
          over_n    = 1'b0;
          winner_n  = 2'b00;
`ifdef PENALTY_SUDDEN_DEATH_EN
          sudden_n  = 1'b0;
`endif
        end
      end
      WAIT_SHOT: begin
        tcnt_n = tcnt + 1'b1;
        if (shot_done || (tcnt == TMO_LAST)) begin
          state_n  = EVAL;
          window_n = 1'b0;
          if (solo) begin
            if (hit) score_b_n = sat_inc(score_b);
            else     score_a_n = sat_inc(score_a);
          end else if (hit) begin
            if (shooter) score_b_n = sat_inc(score_b);
            else         score_a_n = sat_inc(score_a);
          end
        end
      end
      EVAL: begin
        tcnt_n = '0;
        if (solo) begin
          round_n = round_idx + 1'b1;
          if (round_n == RND_LAST) begin
            fin = 1'b1;
            win = leader(score_a, score_b);
          end
        end else begin
          shooter_n = ~shooter;
          if (shooter) round_n = round_idx + 1'b1;
`ifdef PENALTY_SUDDEN_DEATH_EN
          if (sudden) begin
            if (shooter) begin
              if (score_a != score_b) begin
                fin = 1'b1;
                win = leader(score_a, score_b);
              end else if (round_n == CNT_MAX) begin
                fin = 1'b1;
                win = 2'b11;
              end
            end
          end else
`endif
          if (sa_w + rem_a < sb_w) begin
            fin = 1'b1;
            win = 2'b10;
          end else if (sb_w + rem_b < sa_w) begin
            fin = 1'b1;
            win = 2'b01;
          end else if (shooter && (round_n == RND_LAST)) begin
`ifdef PENALTY_SUDDEN_DEATH_EN
            sudden_n = 1'b1;
`else
            fin = 1'b1;
            win = 2'b11;
`endif
          end
        end
        if (fin) begin
          state_n  = DONE;
          over_n   = 1'b1;
          winner_n = win;
        end else begin
          state_n  = WAIT_SHOT;
          window_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_penalty_match_ctl.sv
// Randomized scoreboard bench for penalty_match_ctl against a rule-level match model.
`timescale 1ns/1ps
module tb_penalty_match_ctl;

  localparam int RND_T = 5;
  localparam int SW    = 4;
  localparam int TMO   = 16;
  localparam int MAXC  = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          solo_enable = 1'b0;
  logic          shot_done = 1'b0;
  logic          goal = 1'b0;
  logic          shot_window, shooter, sudden, match_over;
  logic [SW-1:0] score_a, score_b, round_idx;
  logic [1:0]    winner;

  int total = 0;
  int bad   = 0;

  logic [16:0] expq[$];
  int          plan[$];

  int m_sa, m_sb, m_ka, m_kb, m_rnd, m_win;
  bit m_solo, m_sd, m_over, m_shooter;

  penalty_match_ctl #(.ROUNDS(RND_T), .SCORE_W(SW), .SHOT_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .solo_enable(solo_enable),
    .shot_done(shot_done), .goal(goal), .shot_window(shot_window),
    .shooter(shooter), .score_a(score_a), .score_b(score_b),
    .round_idx(round_idx), .sudden(sudden), .match_over(match_over),
    .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic finish_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  function automatic int lead(input int a, input int b);
    return (a > b) ? 1 : ((b > a) ? 2 : 3);
  endfunction

  function automatic logic [16:0] exp_vec();
    return {4'(m_sa), 4'(m_sb), 4'(m_rnd), m_over ? 1'b0 : m_shooter, m_sd, m_over, 2'(m_win)};
  endfunction

  task automatic model_start(input bit solo);
    m_sa = 0; m_sb = 0; m_ka = 0; m_kb = 0; m_rnd = 0; m_win = 0;
    m_solo = solo; m_sd = 0; m_over = 0; m_shooter = solo;
  endtask

  // Kick outcome applied as the match rules read: count kicks per side, then
  // ask whether either side can still catch up.
  task automatic model_kick(input bit g);
    bit b_kicked;
    if (m_solo) begin
      if (g) m_sb = (m_sb < MAXC) ? m_sb + 1 : m_sb;
      else   m_sa = (m_sa < MAXC) ? m_sa + 1 : m_sa;
      m_rnd++;
      if (m_rnd == RND_T) begin m_over = 1; m_win = lead(m_sa, m_sb); end
    end else begin
      b_kicked = m_shooter;
      if (b_kicked) begin m_kb++; if (g && m_sb < MAXC) m_sb++; end
      else          begin m_ka++; if (g && m_sa < MAXC) m_sa++; end
      m_rnd = m_kb;
      m_shooter = !m_shooter;
      if (!m_sd) begin
        if (m_sa + (RND_T - m_ka) < m_sb)      begin m_over = 1; m_win = 2; end
        else if (m_sb + (RND_T - m_kb) < m_sa) begin m_over = 1; m_win = 1; end
        else if (m_ka == RND_T && m_kb == RND_T) begin
`ifdef PENALTY_SUDDEN_DEATH_EN
          m_sd = 1;
`else
          m_over = 1; m_win = 3;
`endif
        end
      end else if (b_kicked) begin
        if (m_sa != m_sb)       begin m_over = 1; m_win = lead(m_sa, m_sb); end
        else if (m_rnd == MAXC) begin m_over = 1; m_win = 3; end
      end
    end
  endtask

  // Monitor: every new kick window or end of match presents a snapshot.
  initial begin
    bit          prev_sw = 0, prev_mo = 0;
    logic [16:0] act, req;
    forever begin
      @(negedge clk);
      if (!rst && ((shot_window && !prev_sw) || (match_over && !prev_mo))) begin
        act = {score_a, score_b, round_idx, match_over ? 1'b0 : shooter, sudden, match_over, winner};
        if (expq.size() == 0) begin
          check("unexpected_event", {15'b0, act}, 32'hFFFF_FFFF);
        end else begin
          req = expq.pop_front();
          check("snapshot", {15'b0, act}, {15'b0, req});
        end
      end
      prev_sw = shot_window;
      prev_mo = match_over;
    end
  end

  initial begin
    #5_000_000;
    bad++;
    $display("FAIL watchdog actual=timeout required=finish");
    finish_run();
  end

  task automatic do_start(input bit solo);
    start = 1'b1;
    solo_enable = solo;
    model_start(solo);
    expq.push_back(exp_vec());
    @(negedge clk);
    start = 1'b0;
  endtask

  // v: 0 miss, 1 goal, 2 let the kick time out.
  task automatic kick(input int v);
    int n, d;
    bit g;
    n = 0;
    while (!shot_window && n < 20) begin @(negedge clk); n++; end
    if (!shot_window) begin
      bad++;
      $display("FAIL window_wait actual=0 required=1");
      finish_run();
    end
    solo_enable = 1'($urandom_range(0, 1));
    if (v == 2) begin
      n = 1;
      while (n < 64) begin
        @(negedge clk);
        if (!shot_window) break;
        n++;
      end
      check("timeout_len", n, TMO);
      g = 1'b0;
    end else begin
      d = $urandom_range(0, TMO - 1);
      g = (v == 1);
      repeat (d) @(negedge clk);
      shot_done = 1'b1;
      goal = g;
      start = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      shot_done = 1'b0; goal = 1'b0; start = 1'b0;
    end
    check("eval_phase", {30'b0, shot_window, match_over}, 32'd0);
    if ($urandom_range(0, 1) == 1) begin
      shot_done = 1'b1; goal = 1'b1; start = 1'($urandom_range(0, 1));
    end
    model_kick(g);
    expq.push_back(exp_vec());
    @(negedge clk);
    shot_done = 1'b0; goal = 1'b0; start = 1'b0;
    check("reopen", {30'b0, shot_window, match_over}, m_over ? 32'd1 : 32'd2);
  endtask

  task automatic run_match(input bit solo);
    int k, v;
    do_start(solo);
    k = 0;
    while (!m_over && k < 200) begin
      if (plan.size() > 0) v = plan.pop_front();
      else v = ($urandom_range(0, 7) == 0) ? 2 : int'($urandom_range(0, 1));
      kick(v);
      k++;
    end
    plan.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_state", {14'b0, shot_window, score_a, score_b, round_idx, shooter, sudden, match_over, winner}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    plan = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    run_match(1'b0);
    plan = '{1, 0, 1, 0, 1, 0};
    run_match(1'b0);
    plan = '{1, 0, 1, 1, 0};
    run_match(1'b1);
    plan = '{2, 2};
    run_match(1'b0);

    do_start(1'b0);
    kick(1); kick(1); kick(1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_reset", {14'b0, shot_window, score_a, score_b, round_idx, shooter, sudden, match_over, winner}, 32'd0);
    rst = 1'b0;
    expq.delete();

    for (int i = 0; i < 40; i++) run_match($urandom_range(0, 2) == 0);

    repeat (3) @(negedge clk);
    check("drain", expq.size(), 0);
    finish_run();
  end

endmodule

// File: doc/penalty_match_ctl.md
PENALTY_MATCH_CTL -- requirements
Module: penalty_match_ctl

Interface
REQ-001 Parameter ROUNDS, default 5, regulation kicks per side (1..15).
REQ-002 Parameter SCORE_W, default 4, width of score and round counters.
REQ-003 Parameter SHOT_TIMEOUT, default 65_000_000, clk cycles allowed per kick before it counts as a miss.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse; begins a match.
REQ-007 solo_enable  input  1  mode select; sampled only on an accepted start.
REQ-008 shot_done  input  1  one-cycle pulse; the current kick has finished.
REQ-009 goal  input  1  kick result, valid with shot_done: 1 = goal, 0 = miss or save.
REQ-010 shot_window  output  1  high while a kick is awaited.
REQ-011 shooter  output  1  kicking side: 0 = side A (player), 1 = side B (opponent/CPU).
REQ-012 score_a, score_b  output  SCORE_W each  goals per side.
REQ-013 round_idx  output  SCORE_W  completed kick pairs (solo: completed kicks).
REQ-014 sudden  output  1  high during sudden death.
REQ-015 match_over  output  1  high in DONE.
REQ-016 winner  output  2  00 none, 01 A, 10 B, 11 draw; valid when match_over.

Function
REQ-017 States: IDLE, WAIT_SHOT, EVAL, DONE. Every output is registered.
REQ-018 IDLE/DONE + start: clear scores, round_idx, sudden, winner, and the timeout counter; shooter=0 (multi) or 1 (solo); latch mode; next state WAIT_SHOT.
REQ-019 start in WAIT_SHOT/EVAL is ignored.
REQ-020 WAIT_SHOT: shot_window=1; the timeout counter increments each cycle.
REQ-021 shot_done in WAIT_SHOT: credit the shooter's side if goal=1; move to EVAL on the next edge.
REQ-022 The timeout counter reaching SHOT_TIMEOUT-1 without shot_done is treated as shot_done with goal=0.
REQ-023 shot_done outside WAIT_SHOT is ignored; shot_done and timeout on the same cycle count as shot_done.
REQ-024 EVAL lasts exactly one cycle; scores are visible when EVAL is entered; a new kick opens 2 cycles after shot_done.
REQ-025 EVAL clears the timeout counter.
REQ-026 Multi mode: shooter toggles every kick; round_idx increments after each side-B kick.
REQ-027 Multi mode regulation, early termination after every kick:
  - remaining kicks per side = ROUNDS minus kicks taken by that side.
  - If score_a + rem_a < score_b, B wins.
  - If score_b + rem_b < score_a, A wins.
REQ-028 Multi mode: round_idx==ROUNDS with scores equal enters sudden death (see Configuration).
REQ-029 Sudden death: evaluated after each side-B kick only; unequal scores give the higher side the win.
REQ-030 Sudden death: round_idx reaching 2^SCORE_W-1 with scores equal ends the match as a draw (11).
REQ-031 Solo mode: shooter fixed at 1; score_a counts saves, score_b counts goals; round_idx increments per kick.
REQ-032 Solo mode: the match ends after ROUNDS kicks; higher score wins, equal scores give 11; no sudden death and no early termination.
REQ-033 DONE: match_over=1, shot_window=0; outputs hold until start or rst.
REQ-034 Score counters saturate at 2^SCORE_W-1 and never wrap.

Reset
REQ-035 rst has priority over all inputs, including start, shot_done, and the timeout.
REQ-036 On rst: state IDLE; all counters 0; shooter, sudden, shot_window, match_over 0; winner 00.
REQ-037 rst mid-match discards the match; the next start begins from round 0.

Configuration
REQ-038 Macro PENALTY_SUDDEN_DEATH_EN.
REQ-039 With the macro defined: a regulation tie in multi mode sets sudden=1, returns to WAIT_SHOT with shooter=0, and play continues per REQ-029.
REQ-040 With the macro undefined: a regulation tie ends in DONE with winner=11; sudden stays 0; the sudden-death logic is not synthesised.

Verification
REQ-041 Multi, ROUNDS=5, goals A,B alternate for all 10 kicks with none missed -> after the 10th, scores 5/5 and round_idx=5; with the macro, sudden=1 and shooter=0; without it, match_over=1 and winner=11.
REQ-042 Multi, A scores kicks 1-3, B misses kicks 1-3 -> match_over after A's 4th kick is not reached; DONE entered on EVAL after B's 3rd miss (3 vs 0, B can reach 2), winner=01.
REQ-043 Multi with the macro, 5/5 tie, then A goal and B miss -> winner=01, score_a=6, round_idx=6.
REQ-044 Solo, ROUNDS=5, goals 1,0,1,1,0 -> score_b=3, score_a=2, winner=10, match_over 1 cycle after the 5th EVAL.
REQ-045 SHOT_TIMEOUT=16, no shot_done -> the kick is scored as a miss after 16 cycles, and shot_window reasserts 2 cycles later.
REQ-046 rst asserted in WAIT_SHOT with score 2/1 -> next cycle all outputs are at reset values; start then begins a clean match.
